vga_timing_gen: RTL and testbench

//  Parametrised raster timing generator. Successor to the separate horizontal/vertical counter pair.

---
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator with one-hot H/V region FSMs; define VGA_TIMING_FRAME_CNT_EN to add a 16-bit frame counter
module vga_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1,
  parameter int CNT_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic             line_end,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic [15:0]      frame_cnt,
`endif
  output logic             frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_FP0  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SY0  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_BP0  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_FP0  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SY0  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_BP0  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_region
    $error("vga_timing_gen: every timing region must be non-zero");
  end
  if (2**CNT_W < H_TOTAL || 2**CNT_W < V_TOTAL) begin : g_bad_width
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  typedef enum logic [3:0] {H_ACT = 4'b0001, H_FRONT = 4'b0010, H_SYN = 4'b0100, H_BACK = 4'b1000} h_state_e;
  typedef enum logic [3:0] {V_ACT = 4'b0001, V_FRONT = 4'b0010, V_SYN = 4'b0100, V_BACK = 4'b1000} v_state_e;

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  h_state_e         h_st_q, h_st_d;
  v_state_e         v_st_q, v_st_d;
  logic             hsync_q, vsync_q, active_q, line_end_q, frame_start_q;
  logic             h_wrap, v_wrap;

  // Next counts and region states; regions switch as the next count hits each region's first pixel/line
  always_comb begin
    h_wrap = h_q == H_LAST;
    v_wrap = v_q == V_LAST;
    h_d    = !en ? h_q : h_wrap ? '0 : h_q + 1'b1;
    v_d    = !(en && h_wrap) ? v_q : v_wrap ? '0 : v_q + 1'b1;
    h_st_d = h_st_q;
    v_st_d = v_st_q;
    case (h_st_q)
      H_ACT:   h_st_d = h_d == H_FP0 ? H_FRONT : H_ACT;
      H_FRONT: h_st_d = h_d == H_SY0 ? H_SYN : H_FRONT;
      H_SYN:   h_st_d = h_d == H_BP0 ? H_BACK : H_SYN;
      H_BACK:  h_st_d = h_d == '0 ? H_ACT : H_BACK;
      default: h_st_d = H_ACT;
    endcase
    case (v_st_q)
      V_ACT:   v_st_d = v_d == V_FP0 ? V_FRONT : V_ACT;
      V_FRONT: v_st_d = v_d == V_SY0 ? V_SYN : V_FRONT;
      V_SYN:   v_st_d = v_d == V_BP0 ? V_BACK : V_SYN;
      V_BACK:  v_st_d = v_d == '0 ? V_ACT : V_BACK;
      default: v_st_d = V_ACT;
    endcase
  end

  // Counters, states and flags all load from next-state values so flags match the presented counts
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q           <= '0;
      v_q           <= '0;
      h_st_q        <= H_ACT;
      v_st_q        <= V_ACT;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      active_q      <= 1'b1;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b1;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      h_st_q        <= h_st_d;
      v_st_q        <= v_st_d;
      hsync_q       <= h_st_d == H_SYN ? H_POL : ~H_POL;
      vsync_q       <= v_st_d == V_SYN ? V_POL : ~V_POL;
      active_q      <= h_st_d == H_ACT && v_st_d == V_ACT;
      line_end_q    <= h_d == H_LAST;
      frame_start_q <= h_d == '0 && v_d == '0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  // Count completed frames: only an enabled wrap into (0,0) counts, reset does not
  always_ff @(posedge clk) begin
    if (rst) frame_cnt_q <= '0;
    else if (en && h_wrap && v_wrap) frame_cnt_q <= frame_cnt_q + 16'd1;
  end
  assign frame_cnt = frame_cnt_q;
`endif

  assign h_count     = h_q;
  assign v_count     = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign line_end    = line_end_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed plus random checks of vga_timing_gen against a counting reference model
module tb_vga_timing_gen;
  localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2, SVA = 4, SVF = 1, SVS = 2, SVB = 1;
  localparam int SHT = SHA + SHF + SHS + SHB, SVT = SVA + SVF + SVS + SVB;
  localparam int DHA = 1280, DHF = 110, DHS = 40, DHB = 220, DVA = 720, DVF = 5, DVS = 5, DVB = 20;
  localparam int DHT = DHA + DHF + DHS + DHB, DVT = DVA + DVF + DVS + DVB;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [3:0]  s_h, s_v, n_h, n_v;
  logic [11:0] d_h, d_v;
  logic s_hs, s_vs, s_act, s_le, s_fs;
  logic n_hs, n_vs, n_act, n_le, n_fs;
  logic d_hs, d_vs, d_act, d_le, d_fs;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] s_fc, n_fc, d_fc;
`endif

  int errors = 0, checks = 0;
  int sh = 0, sv = 0, sfc = 0, dh = 0, dv = 0, dfc = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB), .V_ACTIVE(SVA), .V_FP(SVF),
    .V_SYNC(SVS), .V_BP(SVB), .H_POL(1'b1), .V_POL(1'b1), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .en(en), .h_count(s_h), .v_count(s_v), .hsync(s_hs), .vsync(s_vs),
    .active(s_act), .line_end(s_le),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_cnt(s_fc),
`endif
    .frame_start(s_fs));

  vga_timing_gen #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB), .V_ACTIVE(SVA), .V_FP(SVF),
    .V_SYNC(SVS), .V_BP(SVB), .H_POL(1'b0), .V_POL(1'b0), .CNT_W(4)) dut_n (
    .clk(clk), .rst(rst), .en(en), .h_count(n_h), .v_count(n_v), .hsync(n_hs), .vsync(n_vs),
    .active(n_act), .line_end(n_le),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_cnt(n_fc),
`endif
    .frame_start(n_fs));

  vga_timing_gen dut_d (
    .clk(clk), .rst(rst), .en(en), .h_count(d_h), .v_count(d_v), .hsync(d_hs), .vsync(d_vs),
    .active(d_act), .line_end(d_le),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_cnt(d_fc),
`endif
    .frame_start(d_fs));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv(inout int h, inout int v, inout int fc, input int ht, input int vt);
    if (h == ht - 1) begin
      h = 0;
      if (v == vt - 1) begin
        v = 0;
        fc = (fc + 1) & 16'hFFFF;
      end else v++;
    end else h++;
  endtask

  task automatic check_all;
    logic s_sync_h, s_sync_v;
    s_sync_h = sh >= SHA + SHF && sh < SHA + SHF + SHS;
    s_sync_v = sv >= SVA + SVF && sv < SVA + SVF + SVS;
    chk("s_h", s_h, sh);
    chk("s_v", s_v, sv);
    chk("s_hsync", s_hs, s_sync_h);
    chk("s_vsync", s_vs, s_sync_v);
    chk("s_active", s_act, sh < SHA && sv < SVA);
    chk("s_line_end", s_le, sh == SHT - 1);
    chk("s_frame_start", s_fs, sh == 0 && sv == 0);
    chk("n_h", n_h, sh);
    chk("n_v", n_v, sv);
    chk("n_hsync", n_hs, !s_sync_h);
    chk("n_vsync", n_vs, !s_sync_v);
    chk("n_active", n_act, sh < SHA && sv < SVA);
    chk("n_line_end", n_le, sh == SHT - 1);
    chk("n_frame_start", n_fs, sh == 0 && sv == 0);
    chk("d_h", d_h, dh);
    chk("d_v", d_v, dv);
    chk("d_hsync", d_hs, dh >= DHA + DHF && dh < DHA + DHF + DHS);
    chk("d_vsync", d_vs, dv >= DVA + DVF && dv < DVA + DVF + DVS);
    chk("d_active", d_act, dh < DHA && dv < DVA);
    chk("d_line_end", d_le, dh == DHT - 1);
    chk("d_frame_start", d_fs, dh == 0 && dv == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("s_frame_cnt", s_fc, sfc);
    chk("n_frame_cnt", n_fc, sfc);
    chk("d_frame_cnt", d_fc, dfc);
`endif
  endtask

  task automatic step(input logic r, input logic e);
    @(negedge clk);
    rst = r;
    en  = e;
    @(posedge clk);
    if (r) begin
      sh = 0; sv = 0; dh = 0; dv = 0;
    end else if (e) begin
      adv(sh, sv, sfc, SHT, SVT);
      adv(dh, dv, dfc, DHT, DVT);
    end
    #1 check_all();
  endtask

  task automatic run_to(input int th, input int tv);
    for (int i = 0; i < 2000 && !(sh == th && sv == tv); i++) step(1'b0, 1'b1);
    chk("reach_target", sh == th && sv == tv, 1'b1);
  endtask

  initial begin
    int act_cnt, fs_cnt;
    logic [31:0] snap;
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    act_cnt = 0;
    fs_cnt  = 0;
    for (int i = 0; i < SHT * SVT; i++) begin
      act_cnt += int'(s_act);
      fs_cnt  += int'(s_fs);
      step(1'b0, 1'b1);
    end
    chk("frame_active_cycles", act_cnt, 32);
    chk("frame_start_count", fs_cnt, 1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 1649; i++) step(1'b0, 1'b1);
    chk("d_line_end_at_1649", {d_le, 4'h0, d_h}, {1'b1, 4'h0, 12'd1649});
    step(1'b0, 1'b1);
    chk("d_after_line_wrap", {d_le, d_v, d_h}, {1'b0, 12'd1, 12'd0});
    for (int i = 0; i < 800; i++) step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0);
    step(1'b1, 1'b1);
    run_to(5, 2);
    snap = {s_h, s_v, s_hs, s_vs, s_act, s_le, s_fs};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      chk("frozen", {s_h, s_v, s_hs, s_vs, s_act, s_le, s_fs}, snap);
    end
    step(1'b0, 1'b1);
    chk("resume_pos", {s_v, s_h}, {4'd2, 4'd6});
    run_to(11, 6);
    step(1'b1, 1'b1);
    chk("rst_mid_frame_s", {s_h, s_v, s_act, s_fs, s_hs, s_vs}, {4'd0, 4'd0, 4'b1100});
    chk("rst_mid_frame_n", {n_hs, n_vs}, 2'b11);
`ifdef VGA_TIMING_FRAME_CNT_EN
    run_to(SHT - 1, SVT - 1);
    snap = 32'(s_fc);
    step(1'b0, 1'b1);
    chk("frame_cnt_inc", s_fc, snap + 1);
    @(negedge clk);
    force dut_s.frame_cnt_q = 16'hFFFF;
    force dut_n.frame_cnt_q = 16'hFFFF;
    #1;
    release dut_s.frame_cnt_q;
    release dut_n.frame_cnt_q;
    sfc = 16'hFFFF;
    run_to(SHT - 1, SVT - 1);
    step(1'b0, 1'b1);
    chk("frame_cnt_wrap", s_fc, 16'h0000);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
